bus_mem_resp: RTL and testbench

BUS_MEM_RESP -- requirements
Module: bus_mem_resp

---
 rtl/bus_mem_resp_if.sv | 22 ++
 rtl/bus_mem_resp.sv | 128 ++++++++++++
 tb/tb_bus_mem_resp.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_mem_resp_if.sv
// Request/response bundle between an initiator and the bus_mem_resp memory slave.
// The initiator drives the request fields; the slave returns data beats.
interface bus_mem_resp_if;
  logic        cs;
  logic [1:0]  sel;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] bus;
  logic        ready;
  logic        last;
  logic        err;

  modport master (
    output cs, sel, addr, wdata,
    input  bus, ready, last, err
  );

  modport slave (
    input  cs, sel, addr, wdata,
    output bus, ready, last, err
  );
endinterface

// File: rtl/bus_mem_resp.sv
// Word-addressed memory slave with programmable wait states, two-beat fetch,
// error beats for bad requests and a release handshake on cs.
module bus_mem_resp #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input logic           clk,
  input logic           reset,
  bus_mem_resp_if.slave bus_if
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_BEAT0   = 3'd2;
  localparam logic [2:0] ST_BEAT1   = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam logic [1:0] OP_FETCH = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES - 1);

  logic [15:0]   mem [DEPTH];
  logic [2:0]    state;
  logic [3:0]    wait_cnt;
  logic [1:0]    sel_q;
  logic [15:0]   addr_q;
  logic [15:0]   wdata_q;
  logic          bad_q;
  logic          req_ok;
  logic [AW-1:0] idx0;
  logic [AW-1:0] idx1;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    req_ok = (32'(bus_if.addr) < DEPTH) && (bus_if.sel != OP_RSVD);
    idx0   = addr_q[AW-1:0];
    idx1   = (32'(addr_q) == DEPTH - 1) ? '0 : AW'(addr_q + 16'd1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      sel_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      bad_q        <= 1'b0;
      bus_if.bus   <= '0;
      bus_if.ready <= 1'b0;
      bus_if.last  <= 1'b0;
      bus_if.err   <= 1'b0;
    end else begin
      // Outputs are single-cycle pulses; beat states re-assert them explicitly.
      bus_if.bus   <= '0;
      bus_if.ready <= 1'b0;
      bus_if.last  <= 1'b0;
      bus_if.err   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus_if.cs) begin
            sel_q   <= bus_if.sel;
            addr_q  <= bus_if.addr;
            wdata_q <= bus_if.wdata;
            bad_q   <= !req_ok;
            if (WAIT_STATES == 0) begin
              state <= ST_BEAT0;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end

        ST_WAIT: begin
          if (wait_cnt == 4'd0) state <= ST_BEAT0;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end

        ST_BEAT0: begin
          bus_if.ready <= 1'b1;
          state        <= ST_RELEASE;
          if (bad_q) begin
            bus_if.last <= 1'b1;
            bus_if.err  <= 1'b1;
          end else begin
            case (sel_q)
              OP_FETCH: begin
                bus_if.bus <= mem[idx0];
                state      <= ST_BEAT1;
              end
              OP_READ: begin
                bus_if.bus  <= mem[idx0];
                bus_if.last <= 1'b1;
              end
              default: bus_if.last <= 1'b1;
            endcase
          end
        end

        ST_BEAT1: begin
          bus_if.bus   <= mem[idx1];
          bus_if.ready <= 1'b1;
          bus_if.last  <= 1'b1;
          state        <= ST_RELEASE;
        end

        ST_RELEASE: begin
          if (!bus_if.cs) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the memory array has no reset; its contents must survive a reset.
  always_ff @(posedge clk) begin
    if (state == ST_BEAT0 && !bad_q && sel_q == OP_WRITE) mem[idx0] <= wdata_q;
  end

endmodule

// File: tb/tb_bus_mem_resp.sv
// Self-checking bench: two instances (one and zero wait states) share stimulus;
// a scoreboard per instance checks every beat, its latency, and idle outputs.
module tb_bus_mem_resp;

  typedef struct packed {
    logic [15:0] bus;
    logic        last;
    logic        err;
  } beat_t;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp0;
    logic [15:0] exp1;
    logic        two;
    logic        err;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        cs;
  logic [1:0]  sel;
  logic [15:0] addr;
  logic [15:0] wdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int latch_cyc = 0;
  logic first_pend [2];
  logic mon_en;
  beat_t q0 [$];
  beat_t q1 [$];

  bus_mem_resp_if if_w1 ();
  bus_mem_resp_if if_w0 ();

  assign if_w1.cs = cs;  assign if_w1.sel = sel;  assign if_w1.addr = addr;  assign if_w1.wdata = wdata;
  assign if_w0.cs = cs;  assign if_w0.sel = sel;  assign if_w0.addr = addr;  assign if_w0.wdata = wdata;

  bus_mem_resp #(.DEPTH(256), .WAIT_STATES(1)) dut_w1 (
    .clk    (clk),
    .reset  (reset),
    .bus_if (if_w1)
  );

  bus_mem_resp #(.DEPTH(256), .WAIT_STATES(0)) dut_w0 (
    .clk    (clk),
    .reset  (reset),
    .bus_if (if_w0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  // Scoreboard side: d=0 is the one-wait-state instance, d=1 the zero-wait-state one.
  task automatic mon(input int d, input logic [15:0] b, input logic r, input logic l, input logic e);
    beat_t exp_b;
    int    qsize;
    qsize = (d == 0) ? q0.size() : q1.size();
    if (r) begin
      if (qsize == 0) begin
        check($sformatf("spurious_ready_d%0d", d), 32'(r), 32'd0);
      end else begin
        if (d == 0) exp_b = q0.pop_front();
        else        exp_b = q1.pop_front();
        if (first_pend[d]) begin
          check($sformatf("latency_d%0d", d), 32'(cyc - latch_cyc), 32'(1 + ws_of(d)));
          first_pend[d] = 1'b0;
        end
        check($sformatf("beat_d%0d", d), 32'({b, l, e}), 32'(exp_b));
      end
    end else begin
      check($sformatf("idle_zero_d%0d", d), 32'({b, l, e}), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, if_w1.bus, if_w1.ready, if_w1.last, if_w1.err);
      mon(1, if_w0.bus, if_w0.ready, if_w0.last, if_w0.err);
    end
  end

  task automatic push_both(input beat_t b);
    q0.push_back(b);
    q1.push_back(b);
  endtask

  task automatic drive_vec(input vec_t v);
    cs    = 1'b1;
    sel   = v.sel;
    addr  = v.addr;
    wdata = v.wdata;
    if (v.err) begin
      push_both('{bus: 16'h0000, last: 1'b1, err: 1'b1});
    end else if (v.two) begin
      push_both('{bus: v.exp0, last: 1'b0, err: 1'b0});
      push_both('{bus: v.exp1, last: 1'b1, err: 1'b0});
    end else begin
      push_both('{bus: v.exp0, last: 1'b1, err: 1'b0});
    end
    first_pend[0] = 1'b1;
    first_pend[1] = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(posedge clk);
    end
    check(name, 32'(q0.size() + q1.size()), 32'd0);
  endtask

  // Latch edge, then scramble the request fields and drop cs while the transaction runs.
  task automatic finish_vec(input vec_t v);
    @(posedge clk);
    #1;
    latch_cyc = cyc;
    cs    = 1'b0;
    sel   = ~v.sel;
    addr  = ~v.addr;
    wdata = ~v.wdata;
    drain("drain");
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive_vec(v);
    finish_vec(v);
  endtask

  vec_t vecs [14];
  vec_t v;

  initial begin
    reset = 1'b1;
    cs    = 1'b0;
    sel   = 2'b00;
    addr  = 16'h0000;
    wdata = 16'h0000;
    first_pend[0] = 1'b0;
    first_pend[1] = 1'b0;
    mon_en = 1'b1;

    //            sel    addr      wdata     exp0      exp1      two   err
    vecs[0]  = '{2'b10, 16'h0005, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 16'h0005, 16'h0000, 16'hBEEF, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{2'b10, 16'h0010, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{2'b10, 16'h0011, 16'hABCD, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{2'b00, 16'h0010, 16'h0000, 16'h1234, 16'hABCD, 1'b1, 1'b0};
    vecs[5]  = '{2'b10, 16'h00FF, 16'h7777, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{2'b10, 16'h0000, 16'h0A0A, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[7]  = '{2'b00, 16'h00FF, 16'h0000, 16'h7777, 16'h0A0A, 1'b1, 1'b0};
    vecs[8]  = '{2'b01, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[9]  = '{2'b10, 16'h0100, 16'hDEAD, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{2'b01, 16'h0000, 16'h0000, 16'h0A0A, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{2'b11, 16'h0005, 16'h5A5A, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[12] = '{2'b01, 16'h0005, 16'h0000, 16'hBEEF, 16'h0000, 1'b0, 1'b0};
    vecs[13] = '{2'b10, 16'h0003, 16'h1111, 16'h0000, 16'h0000, 1'b0, 1'b0};

    @(negedge clk);
    check("reset_outputs_d0", 32'({if_w1.ready, if_w1.last, if_w1.err, if_w1.bus}), 32'd0);
    check("reset_outputs_d1", 32'({if_w0.ready, if_w0.last, if_w0.err, if_w0.bus}), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // cs held high after a read: only one pulse until cs drops and rises again.
    @(negedge clk);
    drive_vec('{2'b01, 16'h0010, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    latch_cyc = cyc;
    repeat (9) @(posedge clk);
    check("cs_held_one_pulse", 32'(q0.size() + q1.size()), 32'd0);
    @(negedge clk);
    cs = 1'b0;
    run_vec('{2'b01, 16'h0011, 16'h0000, 16'hABCD, 16'h0000, 1'b0, 1'b0});

    // Reset during the wait phase of a write must cancel the write.
    mon_en = 1'b0;
    @(negedge clk);
    cs = 1'b1; sel = 2'b10; addr = 16'h0003; wdata = 16'h5555;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cs    = 1'b0;
    #1;
    check("rst_in_wait_d0", 32'({if_w1.ready, if_w1.last, if_w1.err, if_w1.bus}), 32'd0);
    check("rst_in_wait_d1", 32'({if_w0.ready, if_w0.last, if_w0.err, if_w0.bus}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    run_vec('{2'b01, 16'h0003, 16'h0000, 16'h1111, 16'h0000, 1'b0, 1'b0});

    // Reset in the middle of a ready pulse clears outputs at once.
    mon_en = 1'b0;
    @(negedge clk);
    cs = 1'b1; sel = 2'b01; addr = 16'h0011; wdata = 16'h0000;
    @(posedge clk);
    #1;
    cs = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_w1.ready) break;
    end
    check("pre_rst_beat", 32'({if_w1.ready, if_w1.bus}), 32'({1'b1, 16'hABCD}));
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_d0", 32'({if_w1.ready, if_w1.last, if_w1.err, if_w1.bus}), 32'd0);
    check("async_rst_d1", 32'({if_w0.ready, if_w0.last, if_w0.err, if_w0.bus}), 32'd0);

    // cs already high while reset is released: accepted at the first edge.
    v = '{2'b01, 16'h0005, 16'h0000, 16'hBEEF, 16'h0000, 1'b0, 1'b0};
    @(negedge clk);
    drive_vec(v);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    finish_vec(v);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
